// File: rtl/dc_filter_stream_if.sv
// Point-to-point busy/vld stream: the master drives vld/data, the slave
// answers with busy. A beat moves when vld & ~busy.
interface dc_filter_stream_if #(
    parameter int W = 24
);
    logic         vld;
    logic         busy;
    logic [W-1:0] data;

    modport master (output vld, output data, input busy);
    modport slave  (input vld, input data, output busy);
endinterface

// File: rtl/dc_filter_stream.sv
// Streaming per-channel DC filter over a sliding window of 2^LOG2_WIN pixels:
// emits either the window mean or the pixel re-centred at mid-scale.

module dc_filter_lane #(
    parameter int DW       = 8,
    parameter int LOG2_WIN = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          acc_i,
    input  logic          clr_i,
    input  logic          mode_i,
    input  logic [DW-1:0] x_i,
    input  logic [DW-1:0] old_i,
    output logic [DW-1:0] res_o
);
    localparam int SW = DW + LOG2_WIN;
    localparam logic [DW+1:0] MID = {2'b00, 1'b1, {(DW-1){1'b0}}};

    logic [SW-1:0]        sum_q, sum_d;
    logic [DW-1:0]        mean;
    logic signed [DW+1:0] d;

    // The true window sum never goes negative, so modular arithmetic is exact.
    always_comb begin
        sum_d = sum_q - {{LOG2_WIN{1'b0}}, old_i} + {{LOG2_WIN{1'b0}}, x_i};
        mean  = sum_d[SW-1:LOG2_WIN];
        d     = $signed({2'b00, x_i}) - $signed({2'b00, mean}) + $signed(MID);
        res_o = mean;
        if (mode_i) begin
            if (d[DW+1])    res_o = '0;
            else if (d[DW]) res_o = '1;
            else            res_o = d[DW-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)      sum_q <= '0;
        else if (clr_i)  sum_q <= '0;
        else if (acc_i)  sum_q <= sum_d;
    end
endmodule

module dc_filter_stream #(
    parameter int CH       = 3,
    parameter int DW       = 8,
    parameter int LOG2_WIN = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    dc_filter_stream_if.slave    rgb,
    dc_filter_stream_if.master   result,
    input  logic                 i_mode,
    input  logic                 i_clear,
    output logic                 o_primed
);
    localparam int W   = CH * DW;
    localparam int WIN = 1 << LOG2_WIN;
    localparam logic [LOG2_WIN:0] FILL_MAX  = {1'b1, {LOG2_WIN{1'b0}}};
    localparam logic [LOG2_WIN:0] FILL_LAST = {1'b0, {LOG2_WIN{1'b1}}};

    logic [WIN-1:0][W-1:0] buf_q;
    logic [LOG2_WIN-1:0]   wptr_q, wptr_d;
    logic [LOG2_WIN:0]     fill_q, fill_d;
    logic                  vld_q, vld_d;
    logic [W-1:0]          data_q, data_d;
    logic [W-1:0]          old_w, res_w;
    logic                  accept, full, produce;

    assign rgb.busy      = vld_q & result.busy;
    assign accept        = rgb.vld & ~rgb.busy;
    assign full          = (fill_q == FILL_MAX);
    assign produce       = accept & (full | (fill_q == FILL_LAST));
    assign result.vld    = vld_q;
    assign result.data   = data_q;
    assign o_primed      = full;

    // Slots are written in pointer order, so until the window is full the
    // slot under wptr has never been written and must contribute zero.
    assign old_w = full ? buf_q[wptr_q] : '0;

    for (genvar c = 0; c < CH; c++) begin : g_lane
        dc_filter_lane #(.DW(DW), .LOG2_WIN(LOG2_WIN)) u_lane (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .acc_i  (accept),
            .clr_i  (i_clear),
            .mode_i (i_mode),
            .x_i    (rgb.data[c*DW +: DW]),
            .old_i  (old_w[c*DW +: DW]),
            .res_o  (res_w[c*DW +: DW])
        );
    end

    always_comb begin
        wptr_d = wptr_q;
        fill_d = fill_q;
        vld_d  = vld_q;
        data_d = data_q;
        if (i_clear) begin
            wptr_d = '0;
            fill_d = '0;
            vld_d  = 1'b0;
        end else begin
            if (accept) begin
                wptr_d = wptr_q + 1'b1;
                if (!full) fill_d = fill_q + 1'b1;
            end
            if (produce) begin
                vld_d  = 1'b1;
                data_d = res_w;
            end else if (!result.busy) begin
                vld_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wptr_q <= '0;
            fill_q <= '0;
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            fill_q <= fill_d;
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    // Stale contents are masked by the fill count, so no reset is needed here.
    always_ff @(posedge i_clk) begin
        if (accept && !i_clear) buf_q[wptr_q] <= rgb.data;
    end
endmodule
